// File: rtl/lc3_seq_controller_v3.sv
// Multi-cycle LC-3 sequencer: one-hot stage enables plus a registered memory sub-FSM; 5 cycles per ALU op, +1 per memory access.
// Backpressure: holds FETCH/MEM while complete_instr/complete_data are low, with per-phase timeout abort to UPDPC.
module lc3_seq_controller_v3 #(
    parameter int TIMEOUT_W     = 8,
    parameter int FETCH_TIMEOUT = 200,
    parameter int MEM_TIMEOUT   = 200
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] IR,
    input  logic        complete_instr,
    input  logic        complete_data,
    input  logic [2:0]  psr,
    input  logic [2:0]  NZP,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic        enable_updatePC,
    output logic [1:0]  mem_state,
    output logic        br_taken,
    output logic        stall,
    output logic        timeout_pulse,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        S_INIT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_UPDPC
    } state_t;

    typedef enum logic [1:0] {
        M_READ  = 2'd0,
        M_IND   = 2'd1,
        M_WRITE = 2'd2,
        M_IDLE  = 2'd3
    } mem_t;

    localparam bit                   FETCH_TO_EN = (FETCH_TIMEOUT != 0);
    localparam bit                   MEM_TO_EN   = (MEM_TIMEOUT != 0);
    localparam logic [TIMEOUT_W-1:0] FETCH_LAST  = TIMEOUT_W'(FETCH_TIMEOUT - 1);
    localparam logic [TIMEOUT_W-1:0] MEM_LAST    = TIMEOUT_W'(MEM_TIMEOUT - 1);
    localparam logic [TIMEOUT_W-1:0] CNT_ONE     = TIMEOUT_W'(1);

    state_t               r_state;
    state_t               w_state_nxt;
    mem_t                 r_mem;
    mem_t                 w_mem_nxt;
    logic [TIMEOUT_W-1:0] r_cnt;
    logic                 r_err;
    logic                 r_abort;

    logic w_mem_op;
    logic w_indirect;
    logic w_store;
    logic w_br;
    logic w_jmp;
    logic w_fetch_wait;
    logic w_mem_wait;
    logic w_fetch_to;
    logic w_mem_to;
    logic w_timeout;
    logic w_cnt_clr;
    logic w_unused;

    // Instruction classes; only the opcode field matters here.
    assign w_mem_op   = (IR[13:12] == 2'b10 || IR[13:12] == 2'b11) && (IR[15:14] != 2'b11);
    assign w_indirect = w_mem_op && (IR[15:14] == 2'b10);
    assign w_store    = w_mem_op && (IR[13:12] == 2'b11);
    assign w_br       = (IR[15:12] == 4'b0000);
    assign w_jmp      = (IR[15:12] == 4'b1100);
    assign w_unused   = ^IR[11:0];

    assign w_fetch_wait = (r_state == S_FETCH) && !complete_instr;
    assign w_mem_wait   = (r_state == S_MEM) && (r_mem != M_IDLE) && !complete_data;
    // The wait-cycle terms already exclude a same-cycle handshake, so complete wins.
    assign w_fetch_to   = FETCH_TO_EN && w_fetch_wait && (r_cnt == FETCH_LAST);
    assign w_mem_to     = MEM_TO_EN && w_mem_wait && (r_cnt == MEM_LAST);
    assign w_timeout    = w_fetch_to || w_mem_to;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT:   w_state_nxt = S_FETCH;
            S_FETCH: begin
                if (complete_instr) begin
                    w_state_nxt = S_DECODE;
                end else if (w_fetch_to) begin
                    w_state_nxt = S_UPDPC;
                end
            end
            S_DECODE: w_state_nxt = S_EXEC;
            S_EXEC:   w_state_nxt = w_mem_op ? S_MEM : S_WB;
            S_MEM: begin
                if (w_mem_to) begin
                    w_state_nxt = S_UPDPC;
                end else if (r_mem == M_IDLE) begin
                    w_state_nxt = S_WB;
                end else if ((r_mem == M_READ || r_mem == M_WRITE) && complete_data) begin
                    w_state_nxt = S_WB;
                end
            end
            S_WB:     w_state_nxt = S_UPDPC;
            S_UPDPC:  w_state_nxt = S_FETCH;
            default:  w_state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mem <= M_IDLE;
        end else begin
            r_mem <= w_mem_nxt;
        end
    end

    // The first access is chosen on the EXEC->MEM edge so the MEM phase starts busy.
    always_comb begin
        w_mem_nxt = M_IDLE;
        if (r_state == S_EXEC && w_mem_op) begin
            if (w_indirect) begin
                w_mem_nxt = M_IND;
            end else if (w_store) begin
                w_mem_nxt = M_WRITE;
            end else begin
                w_mem_nxt = M_READ;
            end
        end else if (r_state == S_MEM && !w_mem_to) begin
            w_mem_nxt = r_mem;
            if (complete_data) begin
                case (r_mem)
                    M_IND:   w_mem_nxt = w_store ? M_WRITE : M_READ;
                    M_READ:  w_mem_nxt = M_IDLE;
                    M_WRITE: w_mem_nxt = M_IDLE;
                    default: w_mem_nxt = M_IDLE;
                endcase
            end
        end
    end

    assign w_cnt_clr = ((w_state_nxt == S_FETCH) && (r_state != S_FETCH)) || (w_mem_nxt != r_mem);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cnt <= '0;
        end else if (stall && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    // r_abort marks the UPDPC reached through a timeout so the PC is not redirected.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_err   <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            if (w_timeout) begin
                r_abort <= 1'b1;
            end else if (r_state == S_UPDPC) begin
                r_abort <= 1'b0;
            end
        end
    end

    assign enable_fetch     = (r_state == S_FETCH);
    assign enable_decode    = (r_state == S_DECODE);
    assign enable_execute   = (r_state == S_EXEC);
    assign enable_writeback = (r_state == S_WB) && !(w_store || w_br || w_jmp);
    assign enable_updatePC  = (r_state == S_UPDPC);
    assign mem_state        = r_mem;
    assign br_taken         = enable_updatePC && !r_abort && (w_jmp || (w_br && |(psr & NZP)));
    assign stall            = w_fetch_wait || w_mem_wait;
    assign timeout_pulse    = w_timeout;
    assign timeout_err      = r_err;

endmodule

// File: tb/tb_lc3_seq_controller_v3.sv
// Directed bench for lc3_seq_controller_v3 with short timeouts (fetch 6, mem 4).
module tb_lc3_seq_controller_v3;

    logic        clock;
    logic        reset;
    logic [15:0] IR;
    logic        complete_instr;
    logic        complete_data;
    logic [2:0]  psr;
    logic [2:0]  NZP;
    logic        enable_fetch;
    logic        enable_decode;
    logic        enable_execute;
    logic        enable_writeback;
    logic        enable_updatePC;
    logic [1:0]  mem_state;
    logic        br_taken;
    logic        stall;
    logic        timeout_pulse;
    logic        timeout_err;

    int n_chk = 0;
    int n_err = 0;

    // Observation vector: {fetch,decode,exec,wb,updpc, mem_state[1:0], br_taken, stall, timeout_pulse}
    localparam logic [9:0] IDL  = 10'b00000_11_000;
    localparam logic [9:0] F_OK = 10'b10000_11_000;
    localparam logic [9:0] F_ST = 10'b10000_11_010;
    localparam logic [9:0] DEC  = 10'b01000_11_000;
    localparam logic [9:0] EXE  = 10'b00100_11_000;
    localparam logic [9:0] WB1  = 10'b00010_11_000;
    localparam logic [9:0] WB0  = 10'b00000_11_000;
    localparam logic [9:0] UP0  = 10'b00001_11_000;
    localparam logic [9:0] UP1  = 10'b00001_11_100;

    lc3_seq_controller_v3 #(
        .TIMEOUT_W     (8),
        .FETCH_TIMEOUT (6),
        .MEM_TIMEOUT   (4)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .IR               (IR),
        .complete_instr   (complete_instr),
        .complete_data    (complete_data),
        .psr              (psr),
        .NZP              (NZP),
        .enable_fetch     (enable_fetch),
        .enable_decode    (enable_decode),
        .enable_execute   (enable_execute),
        .enable_writeback (enable_writeback),
        .enable_updatePC  (enable_updatePC),
        .mem_state        (mem_state),
        .br_taken         (br_taken),
        .stall            (stall),
        .timeout_pulse    (timeout_pulse),
        .timeout_err      (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to the next cycle, apply this cycle's handshakes, then check outputs.
    task automatic cyc(input logic ci, input logic cd, input logic [9:0] exp, input string tag);
        @(posedge clock);
        #1;
        complete_instr = ci;
        complete_data  = cd;
        #1;
        chk(tag, {6'd0, enable_fetch, enable_decode, enable_execute, enable_writeback,
                  enable_updatePC, mem_state, br_taken, stall, timeout_pulse}, {6'd0, exp});
    endtask

    task automatic front(input string tag);
        cyc(1'b1, 1'b0, F_OK, {tag, "_fetch"});
        cyc(1'b0, 1'b0, DEC,  {tag, "_dec"});
        cyc(1'b0, 1'b0, EXE,  {tag, "_exe"});
    endtask

    initial begin
        reset          = 1'b1;
        IR             = 16'h1042;
        complete_instr = 1'b0;
        complete_data  = 1'b0;
        psr            = 3'b000;
        NZP            = 3'b000;

        cyc(1'b0, 1'b0, IDL, "rst_init");
        chk("rst_err", {15'd0, timeout_err}, 16'd0);
        reset = 1'b0;

        // ADD: complete_data outside MEM must be ignored
        cyc(1'b1, 1'b0, F_OK, "add_fetch");
        cyc(1'b0, 1'b0, DEC,  "add_dec");
        cyc(1'b0, 1'b1, EXE,  "add_exe");
        cyc(1'b0, 1'b1, WB1,  "add_wb");
        cyc(1'b0, 1'b0, UP0,  "add_upd");

        // LDI: two-cycle waits on both accesses, 9 cycles total
        IR = 16'hA200;
        front("ldi");
        cyc(1'b0, 1'b0, 10'b00000_01_010, "ldi_m1a");
        cyc(1'b0, 1'b1, 10'b00000_01_000, "ldi_m1b");
        cyc(1'b0, 1'b0, 10'b00000_00_010, "ldi_m0a");
        cyc(1'b0, 1'b1, 10'b00000_00_000, "ldi_m0b");
        cyc(1'b0, 1'b0, WB1, "ldi_wb");
        cyc(1'b0, 1'b0, UP0, "ldi_upd");

        // STR after one fetch wait cycle
        IR = 16'h7000;
        cyc(1'b0, 1'b0, F_ST, "str_fwait");
        front("str");
        cyc(1'b0, 1'b1, 10'b00000_10_000, "str_mem");
        cyc(1'b0, 1'b0, WB0, "str_wb");
        cyc(1'b0, 1'b0, UP0, "str_upd");

        // BRz taken
        IR = 16'h0400; psr = 3'b010; NZP = 3'b010;
        front("brt");
        cyc(1'b0, 1'b0, WB0, "brt_wb");
        cyc(1'b0, 1'b0, UP1, "brt_upd");

        // BRnp not taken
        IR = 16'h0A00; NZP = 3'b101;
        front("brn");
        cyc(1'b0, 1'b0, WB0, "brn_wb");
        cyc(1'b0, 1'b0, UP0, "brn_upd");

        // JMP taken regardless of flags
        IR = 16'hC1C0; NZP = 3'b000; psr = 3'b001;
        front("jmp");
        cyc(1'b0, 1'b0, WB0, "jmp_wb");
        cyc(1'b0, 1'b0, UP1, "jmp_upd");

        // LDR with complete_data stuck low: abort on the 4th wait cycle
        IR = 16'h6000;
        front("ldr");
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b0, 1'b0, 10'b00000_00_010, $sformatf("ldr_w%0d", i));
        end
        cyc(1'b0, 1'b0, 10'b00000_00_011, "ldr_to");
        chk("ldr_err_pre", {15'd0, timeout_err}, 16'd0);
        cyc(1'b0, 1'b0, UP0, "ldr_upd");
        chk("ldr_err", {15'd0, timeout_err}, 16'd1);

        // LDR completing in the would-be timeout cycle: complete wins
        front("ldr2");
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b0, 1'b0, 10'b00000_00_010, $sformatf("ldr2_w%0d", i));
        end
        cyc(1'b0, 1'b1, 10'b00000_00_000, "ldr2_win");
        cyc(1'b0, 1'b0, WB1, "ldr2_wb");
        cyc(1'b0, 1'b0, UP0, "ldr2_upd");
        chk("ldr2_err", {15'd0, timeout_err}, 16'd1);

        // Fetch timeout with a JMP on IR: aborted UPDPC must not branch
        IR = 16'hC1C0;
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b0, 1'b0, F_ST, $sformatf("ft_w%0d", i));
        end
        cyc(1'b0, 1'b0, 10'b10000_11_011, "ft_to");
        cyc(1'b0, 1'b0, UP0, "ft_upd");

        // Reset in the middle of an indirect access
        IR = 16'hA200;
        front("rl");
        cyc(1'b0, 1'b0, 10'b00000_01_010, "rl_m1");
        reset = 1'b1;
        cyc(1'b0, 1'b0, IDL, "rl_rst");
        chk("rl_err", {15'd0, timeout_err}, 16'd0);
        reset = 1'b0;
        cyc(1'b1, 1'b0, F_OK, "rl_fetch");
        cyc(1'b0, 1'b0, DEC,  "rl_dec");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
